man_encoder_tx: RTL and testbench
=================================

// Module: man_encoder_tx
// PURPOSE
//   Manchester (IEEE 802.3) transmitter: takes parallel words over a valid/ready handshake and
//   serialises each one as preamble + data bits onto a single encoded line. Runs on the 32 MHz
//   system clock; the default half-bit of 8 clocks gives a 2 Mbit/s line. It is the transmit
//   end of the link whose receiver is the Manchester decoder.
// PARAMETERS
//   DATA_W         8   payload bits per frame, MSB first
//   CLKS_PER_HALF  8   clk_32Mhz cycles per half-bit (>=2); bit period = 2*CLKS_PER_HALF
//   PREAMBLE_BITS  4   alternating sync bits sent before payload, starting with '1' (>=1)
// PORTS
//   clk_32Mhz     in   1       system clock, 32 MHz, rising-edge
//   rst           in   1       reset, asynchronous, active-low
//   tx_data       in   DATA_W  word to send; sampled on handshake
//   tx_valid      in   1       producer has a word
//   tx_ready      out  1       encoder can accept a word (high only in IDLE)
//   encoded_data  out  1       Manchester line output, registered
//   encoded_clk   out  1       bit clock: high in first half-bit, low in second; low when idle
//   tx_busy       out  1       high from handshake until the frame's last half-bit ends
//   tx_done       out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, encoded_data=0, encoded_clk=0, tx_busy=0, tx_done=0,
//     tx_ready=1 after release; shift reg, half-bit counter and bit counter cleared.
//   - Encoding: bit 0 -> high then low; bit 1 -> low then high. Idle line level is 0.
//   - Handshake: transfer when tx_valid && tx_ready at a rising edge; tx_data latched then.
//     tx_valid while busy is ignored (ready=0); word is not consumed.
//   - Latency: first preamble half-bit appears on encoded_data the cycle after the handshake.
//   - FSM: IDLE -> PREAMBLE (PREAMBLE_BITS bits: 1,0,1,0...) -> DATA (DATA_W bits, MSB first)
//     [-> PARITY if enabled] -> IDLE. Each bit lasts exactly 2*CLKS_PER_HALF cycles;
//     the line toggles at the half-bit midpoint and, where needed, at the bit boundary.
//   - Frame length (defaults): (4+8)*16 = 192 cycles; tx_busy high for exactly that many cycles.
//   - Return to IDLE: encoded_data=0, encoded_clk=0, tx_done pulses 1 cycle, tx_ready=1 the
//     same cycle; next handshake earliest that cycle -> minimum 1-cycle idle gap between frames.
//   - Counters: half-bit counter wraps CLKS_PER_HALF-1 -> 0; bit counter width
//     $clog2(PREAMBLE_BITS+DATA_W+1); no counter may overflow for legal parameters.
//   - Reset mid-frame: frame aborted immediately, outputs to reset values, no tx_done.
// CONFIGURATION
//   MAN_TX_PARITY_EN defined: one even-parity bit (XOR of payload) appended after the LSB,
//     encoded like any data bit; frame grows by one bit period (208 cycles default).
//   MAN_TX_PARITY_EN undefined: no parity bit, frame = PREAMBLE_BITS+DATA_W bits.
// TESTING
//   1. Hold rst=0 then release -> encoded_data=0, encoded_clk=0, tx_busy=0, tx_done=0, tx_ready=1.
//   2. Send 0xA5 -> next cycle preamble 1010 then 10100101; each bit 16 cycles, '1'=8 lo/8 hi,
//      '0'=8 hi/8 lo; tx_done pulses at cycle 192 after handshake; decoder loopback returns 0xA5.
//   3. tx_valid held high with 0x3C then 0xC3 -> two frames separated by exactly 1 idle cycle,
//      both words transmitted intact, tx_ready low throughout each frame.
//   4. Change tx_data to 0xFF mid-frame with tx_valid=1 -> current frame unchanged, 0xFF sent
//      only after tx_done/tx_ready.
//   5. Assert rst at cycle 100 of a frame -> outputs 0 asynchronously, no tx_done; after release
//      a new 0x00 frame transmits correctly.
//   6. MAN_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after LSB, frame 208 cycles.

Source files
------------

// File: rtl/man_encoder_tx_if.sv
// Word handshake between a producer and the Manchester transmitter.
// A word moves on a rising edge where tx_valid && tx_ready; tx_data is sampled only then,
// tx_ready never waits on tx_valid, and a held tx_valid with no ready consumes nothing.
interface man_encoder_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/man_encoder_tx.sv
// Manchester (IEEE 802.3) transmitter: preamble + MSB-first payload on one registered line.
// Define MAN_TX_PARITY_EN to append an even-parity bit after the payload LSB.
module man_encoder_tx #(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_HALF = 8,
    parameter int PREAMBLE_BITS = 4
) (
    input  logic             clk_32Mhz,
    input  logic             rst,
    man_encoder_tx_if.slave  tx,
    output logic             encoded_data,
    output logic             encoded_clk,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [1:0]       state_dbg
);
    localparam int HW = $clog2(CLKS_PER_HALF);
    localparam int BW = $clog2(PREAMBLE_BITS + DATA_W + 1);
    localparam logic [HW-1:0] LAST_HALF = HW'(CLKS_PER_HALF - 1);
    localparam logic [BW-1:0] LAST_PRE  = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(PREAMBLE_BITS + DATA_W - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, PARITY} state_t;

    state_t            state, state_n;
    logic [HW-1:0]     half_cnt, half_n;
    logic              second_half, second_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              line_bit, data_n, clk_n, busy_n, done_n;
`ifdef MAN_TX_PARITY_EN
    logic              parity_bit, parity_n;
`endif

    assign tx.tx_ready = (state == IDLE);
    assign state_dbg   = state;

    always_ff @(posedge clk_32Mhz or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            half_cnt     <= '0;
            second_half  <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            encoded_data <= 1'b0;
            encoded_clk  <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
`ifdef MAN_TX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            half_cnt     <= half_n;
            second_half  <= second_n;
            bit_cnt      <= bit_n;
            shreg        <= shreg_n;
            encoded_data <= data_n;
            encoded_clk  <= clk_n;
            tx_busy      <= busy_n;
            tx_done      <= done_n;
`ifdef MAN_TX_PARITY_EN
            parity_bit   <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        half_n   = half_cnt;
        second_n = second_half;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        done_n   = 1'b0;
`ifdef MAN_TX_PARITY_EN
        parity_n = parity_bit;
`endif
        if (state == IDLE) begin
            if (tx.tx_valid) begin
                state_n  = PREAMBLE;
                half_n   = '0;
                second_n = 1'b0;
                bit_n    = '0;
                shreg_n  = tx.tx_data;
`ifdef MAN_TX_PARITY_EN
                parity_n = ^tx.tx_data;
`endif
            end
        end else if (half_cnt != LAST_HALF) begin
            half_n = half_cnt + 1'b1;
        end else begin
            half_n = '0;
            if (!second_half) begin
                second_n = 1'b1;
            end else begin
                // bit boundary: advance to the next bit of the frame
                second_n = 1'b0;
                bit_n    = bit_cnt + 1'b1;
                if (state == PREAMBLE) begin
                    if (bit_cnt == LAST_PRE) state_n = DATA;
                end else if (state == DATA) begin
                    shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    if (bit_cnt == LAST_DATA) begin
`ifdef MAN_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end

        // line level for the upcoming cycle: ~bit in first half, bit in second half
        line_bit = 1'b0;
        case (state_n)
            PREAMBLE: line_bit = ~bit_n[0];
            DATA:     line_bit = shreg_n[DATA_W-1];
`ifdef MAN_TX_PARITY_EN
            PARITY:   line_bit = parity_n;
`endif
            default:  line_bit = 1'b0;
        endcase
        busy_n = (state_n != IDLE);
        clk_n  = busy_n && !second_n;
        data_n = busy_n && (second_n ? line_bit : ~line_bit);
    end
endmodule

// File: tb/tb_man_encoder_tx.sv
// Bench for man_encoder_tx: per-cycle comparison of the line against a frame model
// built from bit position arithmetic, plus literal pins of that model.
module tb_man_encoder_tx;
    localparam int DW  = 8;
    localparam int CPH = 8;
    localparam int PB  = 4;
`ifdef MAN_TX_PARITY_EN
    localparam int FRAME_BITS = PB + DW + 1;
`else
    localparam int FRAME_BITS = PB + DW;
`endif
    localparam int BIT_CYC   = 2 * CPH;
    localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;
    // sample layout: {tx_ready, tx_busy, tx_done, encoded_clk, encoded_data}
    localparam logic [4:0] IDLE_V = 5'b10000;
    localparam logic [4:0] DONE_V = 5'b10100;

    logic           clk_32Mhz;
    logic           rst;
    logic           encoded_data, encoded_clk, tx_busy, tx_done;
    logic [1:0]     state_dbg;
    logic [4:0]     exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;

    man_encoder_tx_if #(.DATA_W(DW)) bus ();

    man_encoder_tx #(.DATA_W(DW), .CLKS_PER_HALF(CPH), .PREAMBLE_BITS(PB)) dut (
        .clk_32Mhz   (clk_32Mhz),
        .rst         (rst),
        .tx          (bus.slave),
        .encoded_data(encoded_data),
        .encoded_clk (encoded_clk),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        clk_32Mhz = 1'b0;
        forever #5 clk_32Mhz = ~clk_32Mhz;
    end
    always @(posedge clk_32Mhz) cyc <= cyc + 1;

    // expected sample idx cycles after the handshake edge; idx == FRAME_CYC is the done cycle
    function automatic logic [4:0] frame_sample(input logic [DW-1:0] w, input int idx);
        int   b;
        logic bv;
        logic first;
        if (idx >= FRAME_CYC) return DONE_V;
        b     = idx / BIT_CYC;
        first = (idx % BIT_CYC) < CPH;
        if (b < PB)           bv = (b % 2 == 0);
        else if (b < PB + DW) bv = w[DW-1-(b-PB)];
        else                  bv = ^w;
        return {1'b0, 1'b1, 1'b0, first, first ? ~bv : bv};
    endfunction

    task automatic check5(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, got, want);
        end
    endtask

    // scoreboard: one comparison per cycle against the expected queue
    always @(negedge clk_32Mhz) begin
        logic [4:0] want;
        logic [4:0] got;
        if (!rst) begin
            exp_q.delete();
            want = IDLE_V;
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
        end else begin
            want = IDLE_V;
        end
        got = {bus.tx_ready, tx_busy, tx_done, encoded_clk, encoded_data};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL line cyc=%0d actual=%b required=%b", cyc, got, want);
        end
        if (rst && bus.tx_valid && bus.tx_ready)
            for (int i = 0; i <= FRAME_CYC; i++) exp_q.push_back(frame_sample(bus.tx_data, i));
    end

    // driver: present w, hold valid until accepted; returns just after the handshake edge
    task automatic send(input logic [DW-1:0] w);
        logic got_it;
        got_it       = 1'b0;
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(negedge clk_32Mhz);
            if (bus.tx_ready && rst) begin
                got_it = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_it) begin
            errors++;
            $display("FAIL accept_timeout word=%h actual=not_accepted required=accepted", w);
        end
        @(posedge clk_32Mhz);
        #1;
    endtask

    initial begin
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        rst          = 1'b1;

        // model pins
        check5("pin_pre1_lo",  frame_sample(8'hA5, 0),   5'b01010);
        check5("pin_pre1_hi",  frame_sample(8'hA5, 8),   5'b01001);
        check5("pin_pre0_hi",  frame_sample(8'hA5, 16),  5'b01011);
        check5("pin_pre0_lo",  frame_sample(8'hA5, 24),  5'b01000);
        check5("pin_msb1",     frame_sample(8'hA5, 64),  5'b01010);
        check5("pin_d6_0",     frame_sample(8'hA5, 80),  5'b01011);
        check5("pin_lsb1_end", frame_sample(8'hA5, 191), 5'b01001);
`ifdef MAN_TX_PARITY_EN
        check5("pin_par_a5",   frame_sample(8'hA5, 192), 5'b01011);
        check5("pin_par_07",   frame_sample(8'h07, 192), 5'b01010);
        check5("pin_done_208", frame_sample(8'h07, 208), DONE_V);
`else
        check5("pin_done_192", frame_sample(8'hA5, 192), DONE_V);
`endif

        // reset then release
        #2 rst = 1'b0;
        repeat (3) @(posedge clk_32Mhz);
        #1 rst = 1'b1;
        check1("rst_data",  encoded_data, 1'b0);
        check1("rst_clk",   encoded_clk,  1'b0);
        check1("rst_busy",  tx_busy,      1'b0);
        check1("rst_done",  tx_done,      1'b0);
        check1("rst_ready", bus.tx_ready, 1'b1);
        repeat (2) @(posedge clk_32Mhz);
        #1;

        // single frame
        send(8'hA5);
        bus.tx_valid = 1'b0;
        repeat (FRAME_CYC + 4) @(posedge clk_32Mhz);
        #1;

        // back-to-back with valid held, then a mid-frame data change
        send(8'h3C);
        send(8'hC3);
        repeat (50) @(posedge clk_32Mhz);
        #1 bus.tx_data = 8'hFF;
        send(8'hFF);
        bus.tx_valid = 1'b0;
        repeat (FRAME_CYC + 3) @(posedge clk_32Mhz);
        #1;

`ifdef MAN_TX_PARITY_EN
        send(8'h07);
        bus.tx_valid = 1'b0;
        repeat (FRAME_CYC + 3) @(posedge clk_32Mhz);
        #1;
`endif

        // random words with random gaps
        for (int n = 0; n < 6; n++) begin
            send(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 0) bus.tx_valid = 1'b0;
            repeat ($urandom_range(0, 5)) @(posedge clk_32Mhz);
            #1;
        end
        bus.tx_valid = 1'b0;

        // reset 100 cycles into a frame, then a clean 0x00 frame
        for (int i = 0; i < 4 * FRAME_CYC && exp_q.size() > 0; i++) @(posedge clk_32Mhz);
        #1;
        send(8'h5A);
        bus.tx_valid = 1'b0;
        repeat (99) @(posedge clk_32Mhz);
        #3 rst = 1'b0;
        #1;
        check1("abort_data",  encoded_data, 1'b0);
        check1("abort_clk",   encoded_clk,  1'b0);
        check1("abort_busy",  tx_busy,      1'b0);
        check1("abort_done",  tx_done,      1'b0);
        check1("abort_ready", bus.tx_ready, 1'b1);
        repeat (3) @(posedge clk_32Mhz);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk_32Mhz);
        #1;
        send(8'h00);
        bus.tx_valid = 1'b0;

        for (int i = 0; i < 4 * FRAME_CYC && exp_q.size() > 0; i++) @(posedge clk_32Mhz);
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending samples", exp_q.size());
        end
        repeat (4) @(posedge clk_32Mhz);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
